// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Two requester byte streams plus the UART transmitter launch
//               handshake shared by the arbiter and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_ready;
    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output s0_valid, s0_data, s1_valid, s1_data, tx_busy,
        input  s0_ready, s1_ready, tx_start, tx_data
    );

    modport slave (
        input  s0_valid, s0_data, s1_valid, s1_data, tx_busy,
        output s0_ready, s1_ready, tx_start, tx_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Two per-requester byte FIFOs feeding one UART transmitter
//               through a round-robin launch FSM with a busy-rise watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  wire logic                  wb_clk_i,
    input  wire logic                  wb_rst_i,
    uart_tx_arbiter_if.slave           bus,
    input  wire logic                  err_clr,
    output logic                       grant_id,
    output logic                       active,
    output logic [$clog2(DEPTH):0]     lvl0,
    output logic [$clog2(DEPTH):0]     lvl1,
    output logic                       timeout_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BUSY_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_LAUNCH    = 2'd1;
    localparam logic [1:0] c_ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

    logic [1:0]         r_state;
    logic               r_sel;
    logic               r_grant;
    logic               r_active;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic               r_err;
    logic [c_CNT_W-1:0] r_cnt;

    logic [1:0]         w_valid;
    logic [1:0]         w_ready;
    logic [1:0]         w_nonempty;
    logic [7:0]         w_in_data [2];
    logic [7:0]         w_head    [2];
    logic [c_LVL_W-1:0] w_lvl     [2];
    logic               w_pick;

    assign w_valid[0]   = bus.s0_valid;
    assign w_valid[1]   = bus.s1_valid;
    assign w_in_data[0] = bus.s0_data;
    assign w_in_data[1] = bus.s1_data;

    // One FIFO per requester; only the FSM's LAUNCH cycle ever pops.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [7:0]         r_mem [DEPTH];
        logic [c_PTR_W-1:0] r_wr_ptr;
        logic [c_PTR_W-1:0] r_rd_ptr;
        logic [c_LVL_W-1:0] r_lvl;
        logic               w_push;
        logic               w_pop;

        assign w_ready[gi]    = (r_lvl != c_LVL_FULL);
        assign w_push         = w_valid[gi] & w_ready[gi];
        assign w_pop          = (r_state == c_ST_LAUNCH) && (r_sel == 1'(gi));
        assign w_nonempty[gi] = (r_lvl != '0);
        assign w_head[gi]     = r_mem[r_rd_ptr];
        assign w_lvl[gi]      = r_lvl;

        always_ff @(posedge wb_clk_i) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in_data[gi];
            end
        end

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_lvl    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_lvl <= r_lvl + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_lvl <= r_lvl - 1'b1;
                end
            end
        end
    end

    // Both pending: alternate away from the last grant; else take the one pending.
    assign w_pick = (&w_nonempty) ? ~r_grant : w_nonempty[1];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= c_ST_IDLE;
            r_sel      <= 1'b0;
            r_grant    <= 1'b1;
            r_active   <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_tx_start <= 1'b0;
            if (err_clr) begin
                r_err <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_nonempty) begin
                        r_state    <= c_ST_LAUNCH;
                        r_sel      <= w_pick;
                        r_grant    <= w_pick;
                        r_active   <= 1'b1;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_head[w_pick];
                    end
                end
                c_ST_LAUNCH: begin
                    r_state <= c_ST_WAIT_BUSY;
                    r_cnt   <= '0;
                end
                c_ST_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        r_state <= c_ST_WAIT_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        // Assigned after the clear above so a same-cycle timeout keeps the flag set.
                        r_state  <= c_ST_IDLE;
                        r_active <= 1'b0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_state  <= c_ST_IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s0_ready = w_ready[0];
    assign bus.s1_ready = w_ready[1];
    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign grant_id     = r_grant;
    assign active       = r_active;
    assign lvl0         = w_lvl[0];
    assign lvl1         = w_lvl[1];
    assign timeout_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Bench for uart_tx_arbiter using queue-based arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int c_DEPTH = 4;
    localparam int c_TO    = 16;

    typedef struct {
        logic [7:0] d;
        int         vis;
    } ent_t;

    logic       clk;
    logic       rst;
    logic       err_clr;
    logic       grant_id;
    logic       active;
    logic [2:0] lvl0;
    logic [2:0] lvl1;
    logic       timeout_err;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .DEPTH        (c_DEPTH),
        .BUSY_TIMEOUT (c_TO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .bus         (bus),
        .err_clr     (err_clr),
        .grant_id    (grant_id),
        .active      (active),
        .lvl0        (lvl0),
        .lvl1        (lvl1),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_launch = -100;
    ent_t       q0[$];
    ent_t       q1[$];
    logic [7:0] launched[$];
    logic       m_grant = 1'b1;
    int         m_lvl0 = 0;
    int         m_lvl1 = 0;
    bit         acc0, acc1;
    bit         launched_now = 0;
    int         bfm_len = 2;
    bit         bfm_hold = 0;
    int         busy_left = 0;

    // Checks the cycle just entered: launch choice, data, grant, occupancy.
    task automatic observe();
        bit a0, a1, pick;
        logic [7:0] exp_d;
        launched_now = 0;
        pick = 0;
        if (bus.tx_start === 1'b1) begin
            a0 = (q0.size() > 0) && (q0[0].vis <= cyc - 1);
            a1 = (q1.size() > 0) && (q1[0].vis <= cyc - 1);
            checks++;
            if (!a0 && !a1) begin
                errors++;
                $display("FAIL launch_empty: tx_start=1 data=%02h at cycle %0d, required no launch", bus.tx_data, cyc);
            end else begin
                pick = (a0 && a1) ? ~m_grant : a1;
                exp_d = pick ? q1[0].d : q0[0].d;
                if (bus.tx_data !== exp_d) begin
                    errors++;
                    $display("FAIL launch_data: got %02h required %02h at cycle %0d", bus.tx_data, exp_d, cyc);
                end
                checks++;
                if (grant_id !== pick) begin
                    errors++;
                    $display("FAIL launch_grant: got %0b required %0b at cycle %0d", grant_id, pick, cyc);
                end
                checks++;
                if (cyc - last_launch < 4) begin
                    errors++;
                    $display("FAIL launch_spacing: got %0d cycles required >=4 at cycle %0d", cyc - last_launch, cyc);
                end
                if (pick) void'(q1.pop_front()); else void'(q0.pop_front());
                m_grant = pick;
                launched.push_back(bus.tx_data);
                last_launch = cyc;
                launched_now = 1;
                if (bfm_len > 0) busy_left = bfm_len;
            end
        end
        m_lvl0 = q0.size() + ((launched_now && !pick) ? 1 : 0);
        m_lvl1 = q1.size() + ((launched_now && pick) ? 1 : 0);
        checks++;
        if (lvl0 !== 3'(m_lvl0) || bus.s0_ready !== (m_lvl0 != c_DEPTH)) begin
            errors++;
            $display("FAIL lvl0: got lvl=%0d rdy=%0b required lvl=%0d rdy=%0b at cycle %0d",
                     lvl0, bus.s0_ready, m_lvl0, (m_lvl0 != c_DEPTH), cyc);
        end
        checks++;
        if (lvl1 !== 3'(m_lvl1) || bus.s1_ready !== (m_lvl1 != c_DEPTH)) begin
            errors++;
            $display("FAIL lvl1: got lvl=%0d rdy=%0b required lvl=%0d rdy=%0b at cycle %0d",
                     lvl1, bus.s1_ready, m_lvl1, (m_lvl1 != c_DEPTH), cyc);
        end
        bus.tx_busy = bfm_hold || (busy_left > 0);
        if (busy_left > 0) busy_left--;
    endtask

    task automatic tick();
        acc0 = 0;
        acc1 = 0;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_grant = 1'b1;
            last_launch = -100;
        end else begin
            if (bus.s0_valid && m_lvl0 != c_DEPTH) begin
                q0.push_back('{bus.s0_data, cyc + 1});
                acc0 = 1;
            end
            if (bus.s1_valid && m_lvl1 != c_DEPTH) begin
                q1.push_back('{bus.s1_data, cyc + 1});
                acc1 = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        busy_left = 0;
        bfm_hold = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input bit req, input logic [7:0] d);
        int n = 0;
        bit done = 0;
        if (req) begin bus.s1_valid = 1'b1; bus.s1_data = d; end
        else     begin bus.s0_valid = 1'b1; bus.s0_data = d; end
        while (!done && n < 100) begin
            tick();
            done = req ? acc1 : acc0;
            n++;
        end
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_stall: byte %02h on s%0d not accepted in 100 cycles", d, req);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && active === 1'b0) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL drain: q0=%0d q1=%0d active=%0b, required empty and idle within 2000 cycles",
                     q0.size(), q1.size(), active);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (lvl0 !== 3'd0 || lvl1 !== 3'd0) begin
            errors++; $display("FAIL reset_lvl: got %0d/%0d required 0/0", lvl0, lvl1);
        end
        checks++;
        if (bus.s0_ready !== 1'b1 || bus.s1_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %0b/%0b required 1/1", bus.s0_ready, bus.s1_ready);
        end
        checks++;
        if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx: got start=%0b data=%02h required 0/00", bus.tx_start, bus.tx_data);
        end
        checks++;
        if (grant_id !== 1'b1 || active !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got grant=%0b active=%0b err=%0b required 1/0/0",
                               grant_id, active, timeout_err);
        end
    endtask

    task automatic test_single();
        bfm_len = 3;
        send(1'b0, 8'h3D);
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h3D || grant_id !== 1'b0) begin
            errors++; $display("FAIL single_launch: got start=%0b data=%02h grant=%0b required 1/3d/0",
                               bus.tx_start, bus.tx_data, grant_id);
        end
        tick();
        checks++;
        if (lvl0 !== 3'd0 || bus.tx_start !== 1'b0) begin
            errors++; $display("FAIL single_after: got lvl0=%0d start=%0b required 0/0", lvl0, bus.tx_start);
        end
        drain();
    endtask

    task automatic test_tie();
        logic [7:0] exp_t [4] = '{8'h11, 8'h21, 8'h12, 8'h22};
        int base;
        do_reset();
        bfm_len = 10;
        base = launched.size();
        bus.s0_valid = 1'b1; bus.s0_data = 8'h11;
        bus.s1_valid = 1'b1; bus.s1_data = 8'h21;
        tick();
        bus.s0_data = 8'h12;
        bus.s1_data = 8'h22;
        tick();
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        drain();
        checks++;
        if (launched.size() - base != 4) begin
            errors++; $display("FAIL tie_count: got %0d launches required 4", launched.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (launched[base + k] !== exp_t[k]) begin
                    errors++; $display("FAIL tie_order[%0d]: got %02h required %02h", k, launched[base + k], exp_t[k]);
                end
            end
        end
    endtask

    task automatic test_full();
        int base, t0;
        bfm_hold = 1;
        bfm_len = 2;
        base = launched.size();
        t0 = cyc;
        for (int k = 0; k < 5; k++) send(1'b1, 8'(8'h51 + k));
        checks++;
        if (cyc - t0 != 5) begin
            errors++; $display("FAIL full_stall: got %0d cycles for 5 bytes required 5", cyc - t0);
        end
        tick();
        checks++;
        if (lvl1 !== 3'd4 || bus.s1_ready !== 1'b0 || active !== 1'b1) begin
            errors++; $display("FAIL full_state: got lvl1=%0d rdy=%0b active=%0b required 4/0/1",
                               lvl1, bus.s1_ready, active);
        end
        bfm_hold = 0;
        drain();
        checks++;
        if (launched.size() - base != 5) begin
            errors++; $display("FAIL full_count: got %0d launches required 5", launched.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (launched[base + k] !== 8'(8'h51 + k)) begin
                    errors++; $display("FAIL full_order[%0d]: got %02h required %02h", k, launched[base + k], 8'(8'h51 + k));
                end
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int l0;
        do_reset();
        bfm_len = 0;
        send(1'b0, 8'hA1);
        send(1'b0, 8'hA2);
        while (!launched_now && n < 20) begin tick(); n++; end
        l0 = cyc;
        wait_cycle(l0 + c_TO);
        checks++;
        if (timeout_err !== 1'b0 || active !== 1'b1) begin
            errors++; $display("FAIL to_early: got err=%0b active=%0b required 0/1", timeout_err, active);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || active !== 1'b0) begin
            errors++; $display("FAIL to_flag: got err=%0b active=%0b required 1/0", timeout_err, active);
        end
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA2) begin
            errors++; $display("FAIL to_next: got start=%0b data=%02h required 1/a2", bus.tx_start, bus.tx_data);
        end
        wait_cycle(l0 + 20);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL to_clear: got %0b required 0", timeout_err);
        end
        wait_cycle(l0 + 2 * c_TO + 2);
        err_clr = 1'b1;
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_clr_race: got %0b required 1", timeout_err);
        end
        tick();
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL to_clear2: got %0b required 0", timeout_err);
        end
        bfm_len = 2;
        drain();
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        bfm_hold = 1;
        bfm_len = 2;
        for (int k = 0; k < 4; k++) send(1'b0, 8'(8'hB1 + k));
        tick();
        tick();
        checks++;
        if (lvl0 !== 3'd3 || active !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got lvl0=%0d active=%0b required 3/1", lvl0, active);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bfm_hold = 0;
        busy_left = 0;
        checks++;
        if (lvl0 !== 3'd0 || active !== 1'b0 || bus.tx_start !== 1'b0 || bus.s0_ready !== 1'b1
            || grant_id !== 1'b1 || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL mid_reset: got lvl0=%0d active=%0b start=%0b rdy=%0b grant=%0b data=%02h required 0/0/0/1/1/00",
                               lvl0, active, bus.tx_start, bus.s0_ready, grant_id, bus.tx_data);
        end
        base = launched.size();
        repeat (10) tick();
        checks++;
        if (launched.size() != base) begin
            errors++; $display("FAIL mid_quiet: got %0d launches required 0", launched.size() - base);
        end
    endtask

    task automatic test_wrap();
        int base;
        bfm_len = 1;
        base = launched.size();
        for (int k = 0; k < 3 * c_DEPTH; k++) send(1'b0, 8'(k));
        drain();
        checks++;
        if (launched.size() - base != 3 * c_DEPTH) begin
            errors++; $display("FAIL wrap_count: got %0d required %0d", launched.size() - base, 3 * c_DEPTH);
        end else begin
            for (int k = 0; k < 3 * c_DEPTH; k++) begin
                checks++;
                if (launched[base + k] !== 8'(k)) begin
                    errors++; $display("FAIL wrap_order[%0d]: got %02h required %02h", k, launched[base + k], 8'(k));
                end
            end
        end
    endtask

    task automatic test_random();
        int base;
        int acc_total = 0;
        do_reset();
        base = launched.size();
        for (int n = 0; n < 400; n++) begin
            bus.s0_valid = ($urandom_range(0, 9) < 4);
            bus.s0_data  = 8'($urandom_range(0, 255));
            bus.s1_valid = ($urandom_range(0, 9) < 4);
            bus.s1_data  = 8'($urandom_range(0, 255));
            bfm_len      = $urandom_range(1, 5);
            tick();
            acc_total += int'(acc0) + int'(acc1);
        end
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        drain();
        checks++;
        if (launched.size() - base != acc_total) begin
            errors++; $display("FAIL random_count: got %0d launches required %0d", launched.size() - base, acc_total);
        end
    endtask

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        bus.s0_valid = 1'b0;
        bus.s0_data  = 8'h00;
        bus.s1_valid = 1'b0;
        bus.s1_data  = 8'h00;
        bus.tx_busy  = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_full();
        test_timeout();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
